segdisp_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment scanner between NUM_SRC requesters: CPU debug register, PC, instruction word, cycle count, and so on.
- Grants one source at a time, round-robin, for a fixed dwell period.
- Forwards the granted source's 32-bit word to the scanner's data input. The scanner decodes each byte as 0-9; any other byte value blanks that digit.
- A freeze input holds the current source and word, for example from a debug pushbutton.

---
 rtl/segdisp_pkg.sv | 22 ++
 rtl/segdisp_arbiter_if.sv | 28 ++
 rtl/segdisp_arbiter_rr_pick.sv | 40 ++++
 rtl/segdisp_arbiter.sv | 127 ++++++++++++
 tb/tb_segdisp_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/segdisp_pkg.sv
// Shared constants, state encoding and width helper for the seven-segment
// display arbiter.
package segdisp_pkg;

    localparam logic [31:0] BLANK_WORD = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Bits needed to index n sources, never less than one.
    function automatic int src_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/segdisp_arbiter_if.sv
// Bundle between the display requesters (master) and the arbiter (slave).
interface segdisp_arbiter_if
    import segdisp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = src_width(NUM_SRC)
);

    logic [NUM_SRC-1:0]    src_req;
    logic [NUM_SRC*32-1:0] src_data;
    logic                  freeze;
    logic [31:0]           disp_data;
    logic                  disp_active;
    logic [SRC_W-1:0]      disp_src;
    logic [NUM_SRC-1:0]    src_grant;
    logic                  switch_pulse;

    modport master (
        output src_req, src_data, freeze,
        input  disp_data, disp_active, disp_src, src_grant, switch_pulse
    );

    modport slave (
        input  src_req, src_data, freeze,
        output disp_data, disp_active, disp_src, src_grant, switch_pulse
    );

endinterface

// File: rtl/segdisp_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_ptr,
// wrapping around so that last_ptr itself is considered last.
module segdisp_arbiter_rr_pick
    import segdisp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = src_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last_ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    logic [NUM_SRC-1:0] rotated;
    int                 offset;
    int                 slot;

    // rotated[k] is the request of the k-th candidate after last_ptr.
    always_comb begin
        rotated = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            rotated[k] = req[(int'(last_ptr) + 1 + k) % NUM_SRC];
        end
        found  = 1'b0;
        offset = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found  = 1'b1;
                offset = k;
            end
        end
        slot = int'(last_ptr) + 1 + offset;
        if (slot >= NUM_SRC) begin
            slot = slot - NUM_SRC;
        end
        idx = SRC_W'(slot);
    end

endmodule

// File: rtl/segdisp_arbiter.sv
// Round-robin sharing of the seven-segment scanner between several word
// sources, with a fixed dwell per grant and a freeze hold.
module segdisp_arbiter
    import segdisp_pkg::*;
#(
    parameter int          NUM_SRC      = 4,
    parameter int          DWELL_CYCLES = 50000000,
    parameter int          CNT_W        = 26,
    parameter logic [31:0] BLANK_WORD   = segdisp_pkg::BLANK_WORD
) (
    input logic             sys_clk,
    input logic             sys_rst,
    segdisp_arbiter_if.slave bus
);

    localparam int               SRC_W      = src_width(NUM_SRC);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [31:0]        disp_data_q, disp_data_d;
    logic               disp_active_q, disp_active_d;
    logic [SRC_W-1:0]   disp_src_q, disp_src_d;
    logic [SRC_W-1:0]   last_ptr_q, last_ptr_d;
    logic [NUM_SRC-1:0] src_grant_q, src_grant_d;
    logic               switch_pulse_q, switch_pulse_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;

    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic               rearb;
    logic [31:0]        words [NUM_SRC];

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            words[i] = bus.src_data[32*i +: 32];
        end
    end

    segdisp_arbiter_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req      (bus.src_req),
        .last_ptr (last_ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Freeze only matters while showing; a frozen expiry is retried once freeze falls.
    always_comb begin
        state_d        = state_q;
        disp_data_d    = disp_data_q;
        disp_active_d  = disp_active_q;
        disp_src_d     = disp_src_q;
        last_ptr_d     = last_ptr_q;
        src_grant_d    = src_grant_q;
        dwell_d        = dwell_q;
        switch_pulse_d = 1'b0;
        rearb          = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d        = SHOW;
                    disp_active_d  = 1'b1;
                    disp_src_d     = pick_idx;
                    last_ptr_d     = pick_idx;
                    src_grant_d    = NUM_SRC'(1) << pick_idx;
                    disp_data_d    = words[pick_idx];
                    dwell_d        = '0;
                    switch_pulse_d = 1'b1;
                end
            end
            SHOW: begin
                if (!bus.freeze) begin
                    rearb = (dwell_q == DWELL_LAST) || !bus.src_req[disp_src_q];
                    if (!rearb) begin
                        dwell_d     = dwell_q + 1'b1;
                        disp_data_d = words[disp_src_q];
                    end else if (pick_found) begin
                        disp_src_d     = pick_idx;
                        last_ptr_d     = pick_idx;
                        src_grant_d    = NUM_SRC'(1) << pick_idx;
                        disp_data_d    = words[pick_idx];
                        dwell_d        = '0;
                        switch_pulse_d = (pick_idx != disp_src_q);
                    end else begin
                        state_d       = IDLE;
                        disp_data_d   = BLANK_WORD;
                        disp_active_d = 1'b0;
                        src_grant_d   = '0;
                        dwell_d       = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            disp_data_q    <= BLANK_WORD;
            disp_active_q  <= 1'b0;
            disp_src_q     <= '0;
            last_ptr_q     <= SRC_W'(NUM_SRC - 1);
            src_grant_q    <= '0;
            switch_pulse_q <= 1'b0;
            dwell_q        <= '0;
        end else begin
            state_q        <= state_d;
            disp_data_q    <= disp_data_d;
            disp_active_q  <= disp_active_d;
            disp_src_q     <= disp_src_d;
            last_ptr_q     <= last_ptr_d;
            src_grant_q    <= src_grant_d;
            switch_pulse_q <= switch_pulse_d;
            dwell_q        <= dwell_d;
        end
    end

    assign bus.disp_data    = disp_data_q;
    assign bus.disp_active  = disp_active_q;
    assign bus.disp_src     = disp_src_q;
    assign bus.src_grant    = src_grant_q;
    assign bus.switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_segdisp_arbiter.sv
// Scoreboard bench for segdisp_arbiter: a per-cycle behavioural model queues
// expected outputs, and a monitor compares them after every rising edge.
module tb_segdisp_arbiter;

    localparam int          N     = 4;
    localparam int          D     = 4;
    localparam logic [31:0] BLANK = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] data;
        logic        active;
        logic [1:0]  src;
        logic [3:0]  grant;
        logic        pulse;
    } exp_t;

    bit   clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    segdisp_arbiter_if #(.NUM_SRC(N)) bus ();

    segdisp_arbiter #(
        .NUM_SRC      (N),
        .DWELL_CYCLES (D),
        .CNT_W        (3),
        .BLANK_WORD   (32'hFFFF_FFFF)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] word_in [N];

    int          m_show;
    int          m_cur;
    int          m_last;
    int          m_left;
    logic [31:0] m_word;
    logic        m_pulse;

    // First requesting source after 'after', wrapping, or -1 if none.
    function automatic int rrPick(input logic [3:0] req, input int after);
        int order[$];
        for (int k = 1; k <= N; k++) order.push_back((after + k) % N);
        foreach (order[j]) begin
            if (req[order[j]]) return order[j];
        end
        return -1;
    endfunction

    task automatic modelStep(input logic r, input logic [3:0] req, input logic frz);
        int p;
        m_pulse = 1'b0;
        if (r) begin
            m_show = 0;
            m_cur  = 0;
            m_last = N - 1;
            m_left = 0;
            m_word = BLANK;
        end else if (m_show == 0 || (!frz && (m_left == 0 || !req[m_cur]))) begin
            p = rrPick(req, m_last);
            if (p < 0) begin
                m_show = 0;
                m_word = BLANK;
            end else begin
                m_pulse = (m_show == 0) || (p != m_cur);
                m_show  = 1;
                m_cur   = p;
                m_last  = p;
                m_left  = D - 1;
                m_word  = word_in[p];
            end
        end else if (!frz) begin
            m_left = m_left - 1;
            m_word = word_in[m_cur];
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] req, input logic frz);
        exp_t e;
        rst          = r;
        bus.src_req  = req;
        bus.freeze   = frz;
        for (int i = 0; i < N; i++) bus.src_data[32*i +: 32] = word_in[i];
        modelStep(r, req, frz);
        e.data   = m_word;
        e.active = (m_show != 0);
        e.src    = 2'(m_cur);
        e.grant  = (m_show != 0) ? 4'(1 << m_cur) : 4'b0;
        e.pulse  = m_pulse;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL scoreboard_empty at cycle %0d: got 0 entries, expected 1", cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("disp_data", bus.disp_data, e.data);
                checkOutput("disp_active", 32'(bus.disp_active), 32'(e.active));
                checkOutput("disp_src", 32'(bus.disp_src), 32'(e.src));
                checkOutput("src_grant", 32'(bus.src_grant), 32'(e.grant));
                checkOutput("switch_pulse", 32'(bus.switch_pulse), 32'(e.pulse));
            end
        end
    end

    initial begin
        logic [3:0] req;
        logic       frz;
        logic       r;
        for (int i = 0; i < N; i++) word_in[i] = 32'h0;
        rst          = 1'b1;
        bus.src_req  = '0;
        bus.freeze   = 1'b0;
        bus.src_data = '0;

        repeat (2) applyStimulus(1'b1, 4'b0000, 1'b0);

        // Alternating two sources with full dwell periods.
        word_in[0] = 32'h0001_0203;
        word_in[2] = 32'h0405_0607;
        repeat (12) applyStimulus(1'b0, 4'b0101, 1'b0);

        // Lone requester keeps its grant across expiries.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        word_in[3] = 32'h0808_0808;
        repeat (12) applyStimulus(1'b0, 4'b1000, 1'b0);

        // Granted source drops early, then everyone drops.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        word_in[1] = 32'h0101_0101;
        repeat (2) applyStimulus(1'b0, 4'b0010, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0);

        // Freeze holds word while the source changes, then releases.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        word_in[0] = 32'h0000_0000;
        applyStimulus(1'b0, 4'b0001, 1'b0);
        word_in[0] = 32'h0909_0909;
        repeat (10) applyStimulus(1'b0, 4'b0011, 1'b1);
        repeat (6) applyStimulus(1'b0, 4'b0011, 1'b0);

        // Freeze across an expiry, then release with the grant dropped.
        repeat (3) applyStimulus(1'b0, 4'b0011, 1'b0);
        repeat (4) applyStimulus(1'b0, 4'b0011, 1'b1);
        applyStimulus(1'b0, 4'b0100, 1'b0);

        // Reset in the middle of a dwell.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b0100, 1'b0);
        applyStimulus(1'b1, 4'b0100, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b1111, 1'b0);

        // All sources requesting: strict rotation.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        repeat (20) applyStimulus(1'b0, 4'b1111, 1'b0);

        req = 4'b0000;
        repeat (400) begin
            word_in[$urandom_range(0, N - 1)] = $urandom();
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            frz = ($urandom_range(0, 5) == 0);
            r   = ($urandom_range(0, 63) == 0);
            applyStimulus(r, req, frz);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
